// File: rtl/ula_sequenciador.sv
// Multi-cycle control unit sequencing instruction fetch, register-file
// access, the combinational 16-bit ALU and write-back for one instruction
// at a time (FETCH -> DECODE -> EXEC -> WRITE), with branch resolution
// from the ALU condition flag.
module ula_sequenciador #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int RF_AW  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic [RF_AW-1:0]  rf_raddr1,
    output logic [RF_AW-1:0]  rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic              rf_we,
    output logic [RF_AW-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [4:0]        alu_opcode,
    input  logic [31:0]       alu_result,
    input  logic              alu_flag,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_JMP  = 5'b00011;
    localparam logic [4:0] OP_DIV  = 5'b00111;
    localparam logic [4:0] OP_HALT = 5'b11111;

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_res;
    logic              r_flag;

    logic [4:0]        w_op;
    logic [RF_AW-1:0]  w_rd;
    logic [RF_AW-1:0]  w_rs1;
    logic [RF_AW-1:0]  w_rs2;
    logic [15:0]       w_imm;
    logic              w_is_nop;
    logic              w_is_ldi;
    logic              w_is_jmp;
    logic              w_is_halt;
    logic              w_is_alu;
    logic              w_is_branch;
    logic              w_is_illegal;
    logic              w_div0;
    logic              w_write;
    logic              w_jump;
    logic              w_idle_or_halt;

    assign w_op  = r_ir[31:27];
    assign w_rd  = r_ir[26:23];
    assign w_rs1 = r_ir[22:19];
    assign w_rs2 = r_ir[18:15];
    assign w_imm = r_ir[15:0];

    assign w_idle_or_halt = (r_state == S_IDLE) || (r_state == S_HALT);

    // Classify the held instruction; everything not recognised is illegal and behaves as a NOP.
    always_comb begin
        w_is_nop     = (w_op == OP_NOP);
        w_is_ldi     = (w_op == OP_LDI);
        w_is_jmp     = (w_op == OP_JMP);
        w_is_halt    = (w_op == OP_HALT);
        w_is_alu     = (w_op == OP_SUB) || ((w_op >= 5'b00100) && (w_op <= 5'b01101));
        w_is_branch  = (w_op >= 5'b01111) && (w_op <= 5'b10011);
        w_is_illegal = !(w_is_nop || w_is_ldi || w_is_jmp || w_is_halt || w_is_alu || w_is_branch);
        w_div0       = (w_op == OP_DIV) && (r_op2 == '0);
        w_write      = (w_is_alu && !w_div0) || w_is_ldi;
        w_jump       = w_is_jmp || (w_is_branch && r_flag);
    end

    // Next-state selection; start is only honoured while parked in IDLE or HALT.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next_state = S_FETCH;
            S_FETCH:  if (imem_ack) w_next_state = S_DECODE;
            S_DECODE: w_next_state = w_is_halt ? S_HALT : S_EXEC;
            S_EXEC:   w_next_state = S_WRITE;
            S_WRITE:  w_next_state = S_FETCH;
            S_HALT:   if (start) w_next_state = S_FETCH;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any instruction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Program counter: cleared on (re)start, stepped on fetch, overwritten by taken jumps.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc <= '0;
        end else if (w_idle_or_halt && start) begin
            r_pc <= '0;
        end else if ((r_state == S_FETCH) && imem_ack) begin
            r_pc <= r_pc + ADDR_W'(1);
        end else if ((r_state == S_WRITE) && w_jump) begin
            r_pc <= w_imm[ADDR_W-1:0];
        end
    end

    // Instruction register captures the fetched word only when memory acknowledges in FETCH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= '0;
        end else if ((r_state == S_FETCH) && imem_ack) begin
            r_ir <= imem_data;
        end
    end

    // Operand latches hold the register-file read data taken during DECODE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op1 <= '0;
            r_op2 <= '0;
        end else if (r_state == S_DECODE) begin
            r_op1 <= rf_rdata1;
            r_op2 <= rf_rdata2;
        end
    end

    // Result and flag latches sample the combinational ALU during EXEC only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_res  <= '0;
            r_flag <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_res  <= alu_result[DATA_W-1:0];
            r_flag <= alu_flag;
        end
    end

    // Per-state output decode; every interface output rests at zero outside its own phase.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = '0;
        rf_raddr1  = '0;
        rf_raddr2  = '0;
        rf_we      = 1'b0;
        rf_waddr   = '0;
        rf_wdata   = '0;
        alu_op1    = '0;
        alu_op2    = '0;
        alu_opcode = '0;
        illegal    = 1'b0;
        case (r_state)
            S_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = r_pc;
            end
            S_DECODE: begin
                rf_raddr1 = w_rs1;
                rf_raddr2 = w_rs2;
            end
            S_EXEC: begin
                if (w_is_alu || w_is_branch) begin
                    alu_op1    = r_op1;
                    alu_op2    = r_op2;
                    alu_opcode = w_op;
                end
            end
            S_WRITE: begin
                if (w_write) begin
                    rf_we    = 1'b1;
                    rf_waddr = w_rd;
                    rf_wdata = w_is_ldi ? w_imm : r_res;
                end
                illegal = w_is_illegal || w_div0;
            end
            default: begin
            end
        endcase
    end

    assign busy   = !w_idle_or_halt;
    assign halted = (r_state == S_HALT);

endmodule
